// File: rtl/mem_bus_master.sv
// Byte-serial initiator for the 64K x 8 system memory: sequences address/strobes and the
// shared tri-state data bus, splitting 16-bit accesses into two little-endian byte transfers.
module mem_bus_master #(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              rw,
    input  logic              word,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [15:0]       wdata_in,
    output logic              ready,
    output logic              done,
    output logic [15:0]       rdata_out,
    output logic [ADDR_W-1:0] address,
    inout  wire  [7:0]        data,
    output logic              we,
    output logic              MEMbus,
    output logic              BUSmem
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        CAPTURE = 3'd3,
        WRITE   = 3'd4,
        RELEASE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t            state_reg, state_next;
    logic              rw_reg;
    logic              word_reg;
    logic [15:0]       wdata_reg;
    logic              index_reg;
    logic [ADDR_W-1:0] address_reg;
    logic [7:0]        lo_reg;
    logic [15:0]       rdata_reg;
    logic              we_reg, membus_reg, busmem_reg, done_reg, drive_reg;
    logic              rw_eff;
    logic              byte_step;
    logic [7:0]        wbyte;

    // At the accept edge the latched direction is not yet valid, so look at the input.
    assign rw_eff    = (state_reg == IDLE) ? rw : rw_reg;
    assign byte_step = ((state_reg == CAPTURE) || (state_reg == RELEASE)) && (state_next == SETUP);
    assign wbyte     = index_reg ? wdata_reg[15:8] : wdata_reg[7:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = SETUP;
            SETUP:   state_next = rw_reg ? WRITE : STROBE;
            STROBE:  state_next = CAPTURE;
            WRITE:   state_next = RELEASE;
            CAPTURE,
            RELEASE: state_next = (word_reg && !index_reg) ? SETUP : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            rw_reg      <= 1'b0;
            word_reg    <= 1'b0;
            wdata_reg   <= 16'h0000;
            index_reg   <= 1'b0;
            address_reg <= '0;
            lo_reg      <= 8'h00;
            rdata_reg   <= 16'h0000;
            we_reg      <= 1'b0;
            membus_reg  <= 1'b0;
            busmem_reg  <= 1'b0;
            done_reg    <= 1'b0;
            drive_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Strobes are registered copies of the decode of the state being entered.
            we_reg     <= (state_next == WRITE);
            busmem_reg <= (state_next == WRITE);
            membus_reg <= (state_next == STROBE) || (state_next == CAPTURE);
            done_reg   <= (state_next == DONE);
            drive_reg  <= (state_next == WRITE) || (state_next == RELEASE) ||
                          ((state_next == SETUP) && rw_eff);

            if ((state_reg == IDLE) && req) begin
                rw_reg      <= rw;
                word_reg    <= word;
                wdata_reg   <= wdata_in;
                address_reg <= addr_in;
                index_reg   <= 1'b0;
            end else if (byte_step) begin
                index_reg   <= 1'b1;
                address_reg <= address_reg + ADDR_W'(1);
            end

            // The final byte is still on the bus at the DONE-entry edge, so fold it in directly.
            if (state_reg == CAPTURE) begin
                if (!index_reg) lo_reg <= data;
                if (state_next == DONE)
                    rdata_reg <= word_reg ? {data, lo_reg} : {8'h00, data};
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_data_drv
        assign data[gi] = drive_reg ? wbyte[gi] : 1'bz;
    end

    assign ready     = (state_reg == IDLE);
    assign done      = done_reg;
    assign rdata_out = rdata_reg;
    assign address   = address_reg;
    assign we        = we_reg;
    assign MEMbus    = membus_reg;
    assign BUSmem    = busmem_reg;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: vector table, hand-written corner sequences and a randomized
// run checked against a byte-array memory model.
module tb_mem_bus_master;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0, rw = 1'b0, word = 1'b0;
    logic [15:0] addr_in = 16'h0000, wdata_in = 16'h0000;
    logic        ready, done, we, MEMbus, BUSmem;
    logic [15:0] rdata_out, address;
    wire  [7:0]  data;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        fill = 1'b0;
    logic [7:0]  fill_seed = 8'h5A;
    logic        probe_en = 1'b0;
    logic        mon_en = 1'b0;
    int          total = 0, bad = 0;

    always #5 clock = ~clock;

    mem_bus_master #(.ADDR_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .rw(rw), .word(word),
        .addr_in(addr_in), .wdata_in(wdata_in), .ready(ready), .done(done),
        .rdata_out(rdata_out), .address(address), .data(data), .we(we),
        .MEMbus(MEMbus), .BUSmem(BUSmem)
    );

    function automatic logic [7:0] pat(input logic [15:0] i, input logic [7:0] s);
        return i[7:0] ^ i[15:8] ^ s ^ 8'h3C;
    endfunction

    // Memory device: drives the bus on MEMbus, stores on we&BUSmem; probe drives 0 to test release.
    assign data = MEMbus ? mem[address] : (probe_en ? 8'h00 : 8'hzz);

    always @(posedge clock) begin
        if (fill) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i), fill_seed);
        end else if (we && BUSmem) begin
            mem[address] <= data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("we_and_membus", {31'd0, we & MEMbus}, 32'd0);
            if (MEMbus) chk("bus_contention", {24'd0, data}, {24'd0, mem[address]});
        end
    end

    task automatic run_access(input logic r, input logic w, input logic [15:0] a,
                              input logic [15:0] wd, output logic [15:0] rd, output int lat);
        @(negedge clock);
        chk("ready_before", {31'd0, ready}, 32'd1);
        rw = r; word = w; addr_in = a; wdata_in = wd; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) chk("addr_at_setup", {16'd0, address}, {16'd0, a});
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
        rd = rdata_out;
    endtask

    typedef struct {
        logic        rw;
        logic        word;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        tv [8];
    logic [15:0] rd, last_rd, ahi;
    int          lat, n_done, ready_cnt, first_ready;
    logic [15:0] done_mask;

    initial begin
        tv[0] = '{1'b1, 1'b0, 16'h1234, 16'h0042, 16'h0000, 4};
        tv[1] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0042, 4};
        tv[2] = '{1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 7};
        tv[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 7};
        tv[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00BE, 4};
        tv[5] = '{1'b1, 1'b1, 16'h2000, 16'h1357, 16'h0000, 7};
        tv[6] = '{1'b0, 1'b1, 16'h2000, 16'h0000, 16'h1357, 7};
        tv[7] = '{1'b0, 1'b0, 16'h2001, 16'h0000, 16'h0013, 4};

        // Reset and memory fill
        fill = 1'b1;
        @(posedge clock);
        #1 fill = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobes", {29'd0, we, MEMbus, BUSmem}, 32'd0);
        chk("rst_address", {16'd0, address}, 32'd0);
        chk("rst_rdata", {16'd0, rdata_out}, 32'd0);
        reset_n = 1'b1;
        mon_en = 1'b1;
        last_rd = 16'h0000;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_access(tv[i].rw, tv[i].word, tv[i].addr, tv[i].wdata, rd, lat);
            $display("vec %0d rw=%0d word=%0d addr=%h wdata=%h rdata=%h lat=%0d",
                     i, tv[i].rw, tv[i].word, tv[i].addr, tv[i].wdata, rd, lat);
            chk("vec_latency", 32'(lat), 32'(tv[i].exp_lat));
            if (tv[i].rw) begin
                ahi = tv[i].addr + 16'd1;
                chk("vec_rdata_hold", {16'd0, rd}, {16'd0, last_rd});
                chk("vec_mem_lo", {24'd0, mem[tv[i].addr]}, {24'd0, tv[i].wdata[7:0]});
                if (tv[i].word) chk("vec_mem_hi", {24'd0, mem[ahi]}, {24'd0, tv[i].wdata[15:8]});
            end else begin
                chk("vec_rdata", {16'd0, rd}, {16'd0, tv[i].exp_rdata});
                last_rd = tv[i].exp_rdata;
            end
            @(negedge clock);
            chk("vec_ready_after", {31'd0, ready}, 32'd1);
            chk("vec_done_pulse", {31'd0, done}, 32'd0);
        end

        // Busy ignore: write request during cycle 2 of a read
        @(negedge clock);
        rw = 1'b0; word = 1'b0; addr_in = 16'h0020; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (done) begin
                n_done++;
                rd = rdata_out;
            end
            if (c == 2) begin
                rw = 1'b1; addr_in = 16'h0010; wdata_in = 16'h00AA; req = 1'b1;
            end
            if (c == 3) req = 1'b0;
        end
        $display("busy: dones=%0d rdata=%h mem10=%h", n_done, rd, mem[16'h0010]);
        chk("busy_one_done", 32'(n_done), 32'd1);
        chk("busy_rdata", {16'd0, rd}, {24'd0, pat(16'h0020, 8'h5A)});
        chk("busy_mem_untouched", {24'd0, mem[16'h0010]}, {24'd0, pat(16'h0010, 8'h5A)});

        // Back-to-back byte reads with req held
        @(negedge clock);
        rw = 1'b0; word = 1'b0; addr_in = 16'h0001; req = 1'b1;
        @(posedge clock);
        #1 addr_in = 16'h0002;
        ready_cnt = 0; first_ready = 0; done_mask = 16'h0000;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (ready && c <= 9) begin
                ready_cnt++;
                if (first_ready == 0) first_ready = c;
            end
            if (done) done_mask[c] = 1'b1;
            if (c == 4) chk("b2b_rdata1", {16'd0, rdata_out}, {24'd0, pat(16'h0001, 8'h5A)});
            if (c == 6) begin
                chk("b2b_addr2", {16'd0, address}, 32'h0002);
                req = 1'b0;
            end
            if (c == 9) chk("b2b_rdata2", {16'd0, rdata_out}, {24'd0, pat(16'h0002, 8'h5A)});
        end
        $display("b2b: first_ready=%0d ready_cycles=%0d done_mask=%h", first_ready, ready_cnt, done_mask);
        chk("b2b_first_ready", 32'(first_ready), 32'd5);
        chk("b2b_ready_cycles", 32'(ready_cnt), 32'd1);
        chk("b2b_done_cycles", {16'd0, done_mask}, 32'h0210);

        // Reset mid-write (held for two edges, req asserted throughout)
        @(negedge clock);
        rw = 1'b1; word = 1'b1; addr_in = 16'h3000; wdata_in = 16'h6677; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst2_in_write", {31'd0, we}, 32'd1);
        reset_n = 1'b0; req = 1'b1;
        @(negedge clock);
        chk("rst2_strobes", {29'd0, we, MEMbus, BUSmem}, 32'd0);
        chk("rst2_ready", {31'd0, ready}, 32'd1);
        chk("rst2_done", {31'd0, done}, 32'd0);
        chk("rst2_address", {16'd0, address}, 32'd0);
        chk("rst2_rdata", {16'd0, rdata_out}, 32'd0);
        probe_en = 1'b1;
        #1 chk("rst2_data_released", {24'd0, data}, 32'd0);
        probe_en = 1'b0;
        @(negedge clock);
        reset_n = 1'b1; req = 1'b0;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        $display("reset: dones_after=%0d mem3000=%h mem3001=%h", n_done, mem[16'h3000], mem[16'h3001]);
        chk("rst2_no_done", 32'(n_done), 32'd0);
        chk("rst2_ready_idle", {31'd0, ready}, 32'd1);
        chk("rst2_committed", {24'd0, mem[16'h3000]}, 32'h77);
        chk("rst2_hi_not_written", {24'd0, mem[16'h3001]}, {24'd0, pat(16'h3001, 8'h5A)});
        last_rd = 16'h0000;

        // Randomized run against the memory model
        @(negedge clock);
        fill_seed = 8'($urandom);
        for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i), fill_seed);
        fill = 1'b1;
        @(posedge clock);
        #1 fill = 1'b0;
        for (int n = 0; n < 200; n++) begin
            logic        r, w;
            logic [15:0] a, wd, a1, exp_rd;
            r  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = 16'hFFFF;
                1:       a = 16'h0000;
                default: a = 16'($urandom_range(0, 31)) + 16'h4000;
            endcase
            wd = 16'($urandom);
            a1 = a + 16'd1;
            run_access(r, w, a, wd, rd, lat);
            chk("rnd_latency", 32'(lat), w ? 32'd7 : 32'd4);
            if (r) begin
                ref_mem[a] = wd[7:0];
                if (w) ref_mem[a1] = wd[15:8];
                chk("rnd_rdata_hold", {16'd0, rd}, {16'd0, last_rd});
                chk("rnd_mem_lo", {24'd0, mem[a]}, {24'd0, ref_mem[a]});
                chk("rnd_mem_hi", {24'd0, mem[a1]}, {24'd0, ref_mem[a1]});
                $display("rnd %0d write word=%0d addr=%h wdata=%h lat=%0d", n, w, a, wd, lat);
            end else begin
                exp_rd = {w ? ref_mem[a1] : 8'h00, ref_mem[a]};
                chk("rnd_rdata", {16'd0, rd}, {16'd0, exp_rd});
                last_rd = exp_rd;
                $display("rnd %0d read word=%0d addr=%h rdata=%h lat=%0d", n, w, a, rd, lat);
            end
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus-side initiator for the 64K x 8 system memory. It accepts byte or 16-bit word read/write requests from the CPU control unit. It sequences the memory strobes (`address`, `we`, `MEMbus`, `BUSmem`) and the shared 8-bit tri-state `data` bus one byte at a time, then returns read data with a single-cycle completion pulse. Word accesses are split into two byte transfers, little-endian.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width; addresses wrap modulo 2^ADDR_W.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  1  request; accepted only on a rising edge where `ready`=1.
- `rw`  in  1  1 = write, 0 = read; latched at accept.
- `word`  in  1  1 = 16-bit access, 0 = byte; latched at accept.
- `addr_in`  in  ADDR_W  start address; latched at accept.
- `wdata_in`  in  16  write data; latched at accept. Byte writes use bits [7:0].
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse at completion, registered.
- `rdata_out`  out  16  read result; byte reads are zero-extended; holds until the next read completes.
- `address`  out  ADDR_W  memory address, registered.
- `data`  inout  8  shared bus. Driven only during write byte phases, otherwise `8'bzzzz_zzzz`.
- `we`  out  1  memory write enable, registered.
- `MEMbus`  out  1  memory-to-bus output enable, registered.
- `BUSmem`  out  1  bus-to-memory write strobe, registered.

## Operation
- FSM states: IDLE, SETUP, STROBE, CAPTURE, WRITE, RELEASE, DONE.
- IDLE with `req`=1: latch `rw`, `word`, `addr_in`, `wdata_in`; set `address`=`addr_in` and byte index=0; go to SETUP.
- SETUP:
  - All strobes are low.
  - On a write, `data` is driven with the current byte.
  - Next state is STROBE (read) or WRITE (write).
- Read path:
  - STROBE: `MEMbus`=1, `we`=0. Next state CAPTURE.
  - CAPTURE: `MEMbus`=1. At the end-of-cycle edge, `data` is sampled into the byte buffer (index 0 → [7:0], index 1 → [15:8]).
- Write path:
  - WRITE: `we`=1, `BUSmem`=1, `data` driven. Memory stores the byte at the end-of-cycle edge.
  - RELEASE: `we`=0, `BUSmem`=0, `data` still driven for hold.
- After CAPTURE or RELEASE:
  - If `word`=1 and index=0: index=1, `address`=`address`+1 (mod 2^ADDR_W), go to SETUP.
  - Otherwise go to DONE.
- DONE:
  - `done`=1 and all strobes are low.
  - For reads, `rdata_out` is loaded at entry to DONE: word → {hi, lo}; byte → {8'h00, lo}.
  - Next state IDLE.
- Write data per index: index 0 → `wdata_in`[7:0], index 1 → [15:8].
- Bus-contention invariant: `data` is never driven while `MEMbus`=1. `we` and `MEMbus` are never high together.
- `req` is ignored outside IDLE. No queueing.
- `rdata_out` is unchanged by writes.

## Timing
- Accept edge E0 is the edge where `req`=1 and `ready`=1.
- Byte access:
  - SETUP, STROBE/WRITE and CAPTURE/RELEASE occupy cycles 1–3.
  - `done` is high in cycle 4.
  - `ready` returns in cycle 5.
  - Back-to-back throughput is 5 cycles per byte access.
- Word access: 6 byte-phase cycles, `done` in cycle 7, `ready` in cycle 8.
- `address` changes only at accept and at the low→high byte step.
- Reset (`reset_n`=0 at an edge), the same values whether idle or mid-transaction:
  - State → IDLE, `ready`=1, `done`=0.
  - `we`=`MEMbus`=`BUSmem`=0, `address`=0, `rdata_out`=0.
  - `data` released to Z.
- Reset during a transaction aborts it with no `done`.
  - A byte already committed at a WRITE edge stays written.
  - `req` is ignored while `reset_n`=0.
- Address wrap: a word access at 16'hFFFF uses 16'hFFFF then 16'h0000.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles mid-write (in WRITE) → next edge `we`=`BUSmem`=`MEMbus`=0, `data`=Z, `ready`=1, `done`=0, `address`=0, `rdata_out`=0.
- Byte write then read:
  - Write 16'h0042 to 16'h1234 → `done` in cycle 4 and memory[16'h1234]=8'h42.
  - Read 16'h1234 → `rdata_out`=16'h0042 with `done` in cycle 4.
- Word wrap: word write 16'hBEEF at 16'hFFFF → mem[16'hFFFF]=8'hEF and mem[16'h0000]=8'hBE; word read at 16'hFFFF → `rdata_out`=16'hBEEF, `done` in cycle 7.
- Busy ignore: pulse `req` (write 16'h00AA to 16'h0010) during cycle 2 of a read from 16'h0020 → no second transaction, mem[16'h0010] unchanged, exactly one `done`.
- Contention check: run 200 random accesses with a checker asserting (`data` driven ∧ `MEMbus`) = 0 and (`we` ∧ `MEMbus`) = 0 every cycle → no violations; read data matches the reference model.
- Back-to-back: hold `req`=1 with byte reads of 16'h0001 then 16'h0002 → the second is accepted exactly 5 cycles after the first accept; `ready` is high for 1 cycle between them.
